// File: rtl/router_pkg.sv
// Shared definitions for the router packet source: widths, header layout,
// FSM state encoding and small byte helpers.
package router_pkg;

    localparam int PKT_DW      = 8;
    localparam int MAX_PAYLOAD = 63;
    localparam int CNT_W       = 7;

    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    localparam logic [1:0] ADDR_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PARITY  = 3'd3,
        ST_GAP     = 3'd4
    } tx_state_e;

    function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] addr);
        logic [7:0] hdr;
        hdr                            = 8'h00;
        hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
        return hdr;
    endfunction

    function automatic logic [PKT_DW-1:0] parity_fold(input logic [PKT_DW-1:0] acc,
                                                      input logic [PKT_DW-1:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Bundle of the packet source's FIFO-load, request and router-facing signals.
interface router_pkt_tx_if
    import router_pkg::*;
#(
    parameter int DW = PKT_DW
);
    logic             wr_en;
    logic [DW-1:0]    wr_data;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             start;
    logic [1:0]       dest_addr;
    logic [5:0]       pay_len;
    logic             corrupt_parity;
    logic             busy;
    logic             pkt_valid;
    logic [DW-1:0]    pkt_data;
    logic             tx_idle;
    logic             tx_done;
    logic             req_err;

    modport master (
        input  wr_en, wr_data, start, dest_addr, pay_len, corrupt_parity, busy,
        output fifo_full, fifo_count, pkt_valid, pkt_data, tx_idle, tx_done, req_err
    );

    modport slave (
        output wr_en, wr_data, start, dest_addr, pay_len, corrupt_parity, busy,
        input  fifo_full, fifo_count, pkt_valid, pkt_data, tx_idle, tx_done, req_err
    );
endinterface

// File: rtl/router_tx_fifo.sv
// Synchronous first-word-fall-through payload FIFO; the head byte is always
// visible on rd_data, pushes when full and pops when empty are ignored.
module router_tx_fifo
    import router_pkg::*;
#(
    parameter int DW    = PKT_DW,
    parameter int DEPTH = 64
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [DW-1:0]    wr_data,
    input  logic             pop,
    output logic [DW-1:0]    rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]    mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign count     = count_r;
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rd_data   = mem_r[rd_ptr_r];

    // Storage array write port.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers payload bytes and, on request,
// emits header, payload and XOR parity under router backpressure.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int DW         = PKT_DW,
    parameter int FIFO_DEPTH = 64,
    parameter int IPG        = 2
)(
    input logic            clock,
    input logic            reset,
    router_pkt_tx_if.master bus
);
    localparam int            GAP_W     = (IPG > 1) ? $clog2(IPG) : 1;
    localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};
    localparam logic [DW-1:0] PAR_FLIP  = {{(DW-1){1'b0}}, 1'b1};

    tx_state_e        state_r, state_s;
    logic [5:0]       len_r, len_s;
    logic [5:0]       remaining_r, remaining_s;
    logic             corrupt_r, corrupt_s;
    logic [DW-1:0]    parity_r, parity_s;
    logic [GAP_W-1:0] gap_r, gap_s;
    logic             pkt_valid_r, pkt_valid_s;
    logic [DW-1:0]    pkt_data_r, pkt_data_s;
    logic             tx_done_r, tx_done_s;
    logic             req_err_r, req_err_s;
    logic             pop_s;
    logic [DW-1:0]    fifo_head_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [DW-1:0]    hdr_s;
    logic             start_ok_s;

    router_tx_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (bus.wr_en),
        .wr_data (bus.wr_data),
        .pop     (pop_s && !fifo_empty_s),
        .rd_data (fifo_head_s),
        .count   (fifo_count_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign hdr_s      = DW'(make_header(bus.pay_len, bus.dest_addr));
    assign start_ok_s = (bus.pay_len != 6'd0) && (bus.dest_addr != ADDR_ILLEGAL)
                        && (fifo_count_s >= {1'b0, bus.pay_len});

    assign bus.fifo_full  = fifo_full_s;
    assign bus.fifo_count = fifo_count_s;
    assign bus.pkt_valid  = pkt_valid_r;
    assign bus.pkt_data   = pkt_data_r;
    assign bus.tx_idle    = (state_r == ST_IDLE);
    assign bus.tx_done    = tx_done_r;
    assign bus.req_err    = req_err_r;

    // Next-state and next-output decode; every byte advances only when busy is low.
    always_comb begin
        state_s     = state_r;
        len_s       = len_r;
        remaining_s = remaining_r;
        corrupt_s   = corrupt_r;
        parity_s    = parity_r;
        gap_s       = gap_r;
        pkt_valid_s = pkt_valid_r;
        pkt_data_s  = pkt_data_r;
        tx_done_s   = 1'b0;
        req_err_s   = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start && start_ok_s) begin
                    state_s     = ST_HEADER;
                    len_s       = bus.pay_len;
                    corrupt_s   = bus.corrupt_parity;
                    pkt_valid_s = 1'b1;
                    pkt_data_s  = hdr_s;
                    parity_s    = hdr_s;
                end else if (bus.start) begin
                    req_err_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (!bus.busy) begin
                    state_s     = ST_PAYLOAD;
                    pkt_data_s  = fifo_head_s;
                    pop_s       = 1'b1;
                    parity_s    = parity_fold(parity_r, fifo_head_s);
                    remaining_s = len_r - 6'd1;
                end else begin
                    state_s = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                if (!bus.busy && (remaining_r != 6'd0)) begin
                    pkt_data_s  = fifo_head_s;
                    pop_s       = 1'b1;
                    parity_s    = parity_fold(parity_r, fifo_head_s);
                    remaining_s = remaining_r - 6'd1;
                end else if (!bus.busy) begin
                    state_s     = ST_PARITY;
                    pkt_valid_s = 1'b0;
                    pkt_data_s  = corrupt_r ? (parity_r ^ PAR_FLIP) : parity_r;
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end
            ST_PARITY: begin
                if (!bus.busy) begin
                    state_s    = ST_GAP;
                    tx_done_s  = 1'b1;
                    pkt_data_s = DATA_ZERO;
                    gap_s      = {GAP_W{1'b0}};
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_GAP: begin
                if (gap_r == GAP_W'(IPG - 1)) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_s = gap_r + GAP_W'(1);
                end
            end
            default: begin
                state_s     = ST_IDLE;
                pkt_valid_s = 1'b0;
                pkt_data_s  = DATA_ZERO;
            end
        endcase
    end

    // State and registered-output update; reset aborts any packet in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            len_r       <= 6'd0;
            remaining_r <= 6'd0;
            corrupt_r   <= 1'b0;
            parity_r    <= DATA_ZERO;
            gap_r       <= {GAP_W{1'b0}};
            pkt_valid_r <= 1'b0;
            pkt_data_r  <= DATA_ZERO;
            tx_done_r   <= 1'b0;
            req_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            len_r       <= len_s;
            remaining_r <= remaining_s;
            corrupt_r   <= corrupt_s;
            parity_r    <= parity_s;
            gap_r       <= gap_s;
            pkt_valid_r <= pkt_valid_s;
            pkt_data_r  <= pkt_data_s;
            tx_done_r   <= tx_done_s;
            req_err_r   <= req_err_s;
        end
    end
endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: a packet-level reference model (byte queues) checked
// against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_router_pkt_tx;
    localparam int DEPTH = 64;
    localparam int IPG   = 2;

    typedef struct {
        int         kind;   // 0 header, 1 payload, 2 parity
        logic [7:0] data;
    } item_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    router_pkt_tx_if #(.DW(8)) bus ();

    router_pkt_tx #(.DW(8), .FIFO_DEPTH(DEPTH), .IPG(IPG)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] fq[$];
    item_t      xq[$];
    logic [7:0] last_pkt[$];
    logic [7:0] hdr_log[$];
    logic [7:0] par_log[$];
    int         gap = 0;
    logic       m_done = 1'b0;
    logic       m_err = 1'b0;
    logic       model_ok = 1'b0;
    int         cyc = 0;
    int         hdr_hist[$];
    int         done_hist[$];
    int         err_pulses = 0;
    logic       prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: a queue of expected bytes that advances on each accepted byte.
    always @(posedge clock) begin
        logic       was_idle;
        int         pre_size;
        int         k;
        logic [7:0] hdr;
        logic [7:0] p;
        cyc++;
        if (reset) begin
            fq.delete();
            xq.delete();
            gap      = 0;
            m_done   = 1'b0;
            m_err    = 1'b0;
            model_ok = 1'b1;
        end else begin
            was_idle = (xq.size() == 0) && (gap == 0);
            pre_size = fq.size();
            m_done   = 1'b0;
            m_err    = 1'b0;
            if (gap > 0) gap--;
            if (xq.size() > 0 && !bus.busy) begin
                k = xq[0].kind;
                void'(xq.pop_front());
                if (xq.size() > 0 && xq[0].kind == 1) void'(fq.pop_front());
                if (k == 2) begin
                    m_done = 1'b1;
                    gap    = IPG;
                end
            end
            if (was_idle && bus.start) begin
                if (bus.pay_len != 0 && bus.dest_addr != 2'd3 && pre_size >= int'(bus.pay_len)) begin
                    hdr = {bus.pay_len, bus.dest_addr};
                    p   = hdr;
                    last_pkt.delete();
                    xq.push_back('{0, hdr});
                    last_pkt.push_back(hdr);
                    for (int i = 0; i < int'(bus.pay_len); i++) begin
                        p = p ^ fq[i];
                        xq.push_back('{1, fq[i]});
                        last_pkt.push_back(fq[i]);
                    end
                    if (bus.corrupt_parity) p = p ^ 8'h01;
                    xq.push_back('{2, p});
                    last_pkt.push_back(p);
                    hdr_log.push_back(hdr);
                    par_log.push_back(p);
                end else begin
                    m_err = 1'b1;
                end
            end
            if (bus.wr_en && pre_size < DEPTH) fq.push_back(bus.wr_data);
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clock) begin
        logic       ev;
        logic [7:0] ed;
        if (model_ok) begin
            if (xq.size() > 0) begin
                ev = (xq[0].kind != 2);
                ed = xq[0].data;
            end else begin
                ev = 1'b0;
                ed = 8'h00;
            end
            check("pkt_valid", 32'(bus.pkt_valid), 32'(ev));
            check("pkt_data", 32'(bus.pkt_data), 32'(ed));
            check("tx_done", 32'(bus.tx_done), 32'(m_done));
            check("req_err", 32'(bus.req_err), 32'(m_err));
            check("tx_idle", 32'(bus.tx_idle), 32'((xq.size() == 0) && (gap == 0)));
            check("fifo_count", 32'(bus.fifo_count), 32'(fq.size()));
            check("fifo_full", 32'(bus.fifo_full), 32'(fq.size() >= DEPTH));
            if (bus.pkt_valid === 1'b1 && !prev_valid) hdr_hist.push_back(cyc);
            if (bus.tx_done === 1'b1) done_hist.push_back(cyc);
            if (bus.req_err === 1'b1) err_pulses++;
            prev_valid = (bus.pkt_valid === 1'b1);
        end
    end

    task automatic push_byte(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        @(negedge clock);
        bus.wr_en   = 1'b0;
    endtask

    task automatic push_seq(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) push_byte(first + 8'(i));
    endtask

    task automatic do_start(input logic [1:0] a, input logic [5:0] l, input logic c);
        bus.start          = 1'b1;
        bus.dest_addr      = a;
        bus.pay_len        = l;
        bus.corrupt_parity = c;
        @(negedge clock);
        bus.start          = 1'b0;
        bus.corrupt_parity = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.tx_idle !== 1'b1 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("idle_timeout", 32'(bus.tx_idle), 32'd1);
    endtask

    task automatic wait_byte(input logic [7:0] b);
        int n = 0;
        while (!(bus.pkt_valid === 1'b1 && bus.pkt_data === b) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("byte_timeout", 32'(bus.pkt_data), 32'(b));
    endtask

    initial begin
        logic [7:0] exp1 [9];
        int         e0;
        exp1 = '{8'h1D, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h1D};
        bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.start = 1'b0; bus.dest_addr = 2'd0;
        bus.pay_len = 6'd0; bus.corrupt_parity = 1'b0; bus.busy = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst_valid", 32'(bus.pkt_valid), 32'd0);
        check("rst_data", 32'(bus.pkt_data), 32'd0);
        check("rst_idle", 32'(bus.tx_idle), 32'd1);
        check("rst_count", 32'(bus.fifo_count), 32'd0);

        // basic packet
        push_seq(7, 8'h01);
        do_start(2'd1, 6'd7, 1'b0);
        wait_idle();
        for (int i = 0; i < 9; i++) check("t1_seq", 32'(last_pkt[i]), 32'(exp1[i]));
        check("t1_latency", 32'(done_hist[$] - hdr_hist[$]), 32'd9);
        check("t1_count", 32'(bus.fifo_count), 32'd0);

        // backpressure on byte 03
        push_seq(7, 8'h01);
        do_start(2'd1, 6'd7, 1'b0);
        wait_byte(8'h03);
        bus.busy = 1'b1;
        repeat (3) @(negedge clock);
        bus.busy = 1'b0;
        wait_idle();
        check("t2_latency", 32'(done_hist[$] - hdr_hist[$]), 32'd12);
        check("t2_parity", 32'(par_log[$]), 32'h1D);

        // rejected requests
        push_seq(4, 8'h10);
        e0 = err_pulses;
        do_start(2'd3, 6'd1, 1'b0);
        @(negedge clock);
        do_start(2'd0, 6'd0, 1'b0);
        @(negedge clock);
        do_start(2'd0, 6'd5, 1'b0);
        @(negedge clock);
        check("t3_err_pulses", 32'(err_pulses - e0), 32'd3);
        check("t3_count", 32'(bus.fifo_count), 32'd4);
        check("t3_idle", 32'(bus.tx_idle), 32'd1);
        do_start(2'd0, 6'd4, 1'b0);
        wait_idle();

        // back-to-back packets
        push_byte(8'hAA); push_byte(8'h55); push_byte(8'h0F);
        do_start(2'd0, 6'd2, 1'b0);
        bus.start = 1'b1; bus.dest_addr = 2'd2; bus.pay_len = 6'd1;
        while (bus.tx_idle !== 1'b1 && cyc < 50000) @(negedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        wait_idle();
        check("t4_par1", 32'(par_log[par_log.size()-2]), 32'hF7);
        check("t4_hdr2", 32'(hdr_log[$]), 32'h06);
        check("t4_par2", 32'(par_log[$]), 32'h09);
        check("t4_gap", 32'(hdr_hist[$] - done_hist[done_hist.size()-2]), 32'(IPG + 1));

        // corrupted parity
        push_seq(7, 8'h01);
        do_start(2'd1, 6'd7, 1'b1);
        wait_idle();
        check("t5_parity", 32'(par_log[$]), 32'h1C);

        // reset mid-packet
        push_seq(7, 8'h01);
        do_start(2'd1, 6'd7, 1'b0);
        wait_byte(8'h04);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t6_valid", 32'(bus.pkt_valid), 32'd0);
        check("t6_data", 32'(bus.pkt_data), 32'd0);
        check("t6_count", 32'(bus.fifo_count), 32'd0);
        check("t6_idle", 32'(bus.tx_idle), 32'd1);
        push_seq(7, 8'h01);
        do_start(2'd1, 6'd7, 1'b0);
        wait_idle();
        check("t6_parity", 32'(par_log[$]), 32'h1D);

        // fill past full, then max-length packet
        push_seq(66, 8'h40);
        check("full_count", 32'(bus.fifo_count), 32'd64);
        check("full_flag", 32'(bus.fifo_full), 32'd1);
        do_start(2'd2, 6'd63, 1'b0);
        wait_idle();
        do_start(2'd0, 6'd1, 1'b0);
        wait_idle();
        check("drain_count", 32'(bus.fifo_count), 32'd0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bus.wr_en          = ($urandom_range(0, 2) == 0);
            bus.wr_data        = 8'($urandom_range(0, 255));
            bus.busy           = ($urandom_range(0, 3) == 0);
            bus.start          = ($urandom_range(0, 5) == 0);
            bus.dest_addr      = 2'($urandom_range(0, 3));
            bus.pay_len        = 6'($urandom_range(0, 24));
            bus.corrupt_parity = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
        bus.wr_en = 1'b0; bus.busy = 1'b0; bus.start = 1'b0; bus.corrupt_parity = 1'b0;
        wait_idle();
        repeat (4) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
